// File: rtl/sram_stream_adapter.sv
// Adapts a valid/ready request stream onto a fixed-latency SRAM port and
// returns read data through a credit-protected response FIFO.
module sram_stream_adapter #(
  parameter int unsigned NumWords      = 1024,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned ByteWidth     = 8,
  parameter int unsigned Latency       = 1,
  parameter int unsigned NumRspEntries = Latency + 2,
  localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = $clog2(NumRspEntries + 1);
  localparam int unsigned PtrWidth = (NumRspEntries > 1) ? $clog2(NumRspEntries) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(NumRspEntries);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumRspEntries - 1);

  logic [CntWidth-1:0]  outstanding_q, outstanding_d;
  logic [Latency-1:0]   vld_q, vld_d;
  logic [PtrWidth-1:0]  wptr_q, rptr_q;
  logic [CntWidth-1:0]  occ_q;
  logic [DataWidth-1:0] fifo_q [NumRspEntries];

  logic req_hs;
  logic rd_acc;
  logic push;
  logic pop;

  // Credits cover both the SRAM pipeline and the FIFO, so ready depends on
  // registered state only and the FIFO can never overflow.
  assign req_ready_o  = (outstanding_q < MaxCnt);
  assign req_hs       = req_valid_i && req_ready_o;
  assign rd_acc       = req_hs && !req_we_i;

  assign sram_req_o   = req_hs;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign push         = vld_q[0];
  assign rsp_valid_o  = (occ_q != '0);
  assign rsp_rdata_o  = fifo_q[rptr_q];
  assign pop          = rsp_valid_o && rsp_ready_i;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // Next outstanding count: +1 on accepted read, -1 on response pop.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({rd_acc, pop})
      2'b10:   outstanding_d = outstanding_q + CntWidth'(1);
      2'b01:   outstanding_d = outstanding_q - CntWidth'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Read-valid pipeline: enters at the top bit, exits at bit 0 with the data.
  always_comb begin
    vld_d              = vld_q >> 1;
    vld_d[Latency-1]   = rd_acc;
  end

  // Credit counter and read-valid pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      vld_q         <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      vld_q         <= vld_d;
    end
  end

  // Response FIFO: circular buffer; push and pop may coincide at any fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < NumRspEntries; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= sram_rdata_i;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push && !pop) begin
        occ_q <= occ_q + CntWidth'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - CntWidth'(1);
      end
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (occ_q == MaxCnt)))
    else $error("response FIFO push while full");

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && !rd_acc && (outstanding_q == '0)))
    else $error("outstanding counter underflow");

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_hs && (32'(req_addr_i) >= NumWords)))
    else $error("request address out of range");
`endif

endmodule

// File: tb/tb_sram_stream_adapter.sv
// Directed self-checking bench for sram_stream_adapter with a 1-cycle SRAM model.
module tb_sram_stream_adapter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_be;
  logic [DW-1:0] sram_rdata;

  logic          init_mem;
  logic [DW-1:0] mem [1024];

  int n_checks = 0;
  int n_errors = 0;
  int n_acc;
  int rx;

  sram_stream_adapter #(
    .NumWords      (1024),
    .DataWidth     (32),
    .ByteWidth     (8),
    .Latency       (1),
    .NumRspEntries (3)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'hA5A5_A5A5;
    if (i == 7) return 32'h0000_0000;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // SRAM model: byte-masked writes, read data returned one cycle later.
  always @(posedge clk_i) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++) begin
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    rst_ni    = 1'b0;
    init_mem  = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_sram_req",  32'(sram_req),  32'd1);
    step();
    step();
    init_mem  = 1'b0;
    req_valid = 1'b0;
    #1;
    check_eq("rst_sram_req_low", 32'(sram_req), 32'd0);
    rst_ni = 1'b1;
    step();

    // Single read of addr 5: response only in cycle 2.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 10'd5;
    @(negedge clk_i);
    check_eq("single_c0_sram_req", 32'(sram_req), 32'd1);
    check_eq("single_c0_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    req_valid = 1'b0;
    @(negedge clk_i);
    check_eq("single_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk_i);
    check_eq("single_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("single_c2_rdata", rsp_rdata, 32'hA5A5_A5A5);
    step();
    @(negedge clk_i);
    check_eq("single_c3_rsp_valid", 32'(rsp_valid), 32'd0);
    step();

    // Backpressure: three credits, then stall; drain releases credits in order.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 10'd1;
    @(negedge clk_i);
    check_eq("bp_c0_ready", 32'(req_ready), 32'd1);
    step();
    req_addr = 10'd2;
    @(negedge clk_i);
    check_eq("bp_c1_ready", 32'(req_ready), 32'd1);
    step();
    req_addr = 10'd3;
    @(negedge clk_i);
    check_eq("bp_c2_ready", 32'(req_ready), 32'd1);
    check_eq("bp_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp_c2_rdata", rsp_rdata, 32'hC0DE_0001);
    step();
    req_addr = 10'd4;
    @(negedge clk_i);
    check_eq("bp_c3_ready", 32'(req_ready), 32'd0);
    check_eq("bp_c3_sram_req", 32'(sram_req), 32'd0);
    step();
    @(negedge clk_i);
    check_eq("bp_c4_ready", 32'(req_ready), 32'd0);
    check_eq("bp_c4_rdata_hold", rsp_rdata, 32'hC0DE_0001);
    step();
    @(negedge clk_i);
    check_eq("bp_c5_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp_c5_rdata_hold", rsp_rdata, 32'hC0DE_0001);
    step();
    rsp_ready = 1'b1;
    @(negedge clk_i);
    check_eq("bp_c6_ready_full", 32'(req_ready), 32'd0);
    check_eq("bp_c6_rdata", rsp_rdata, 32'hC0DE_0001);
    step();
    @(negedge clk_i);
    check_eq("bp_c7_ready_after_pop", 32'(req_ready), 32'd1);
    check_eq("bp_c7_sram_req", 32'(sram_req), 32'd1);
    check_eq("bp_c7_rdata", rsp_rdata, 32'hC0DE_0002);
    step();
    req_valid = 1'b0;
    @(negedge clk_i);
    check_eq("bp_c8_ready_acc_pop", 32'(req_ready), 32'd1);
    check_eq("bp_c8_rdata", rsp_rdata, 32'hC0DE_0003);
    step();
    @(negedge clk_i);
    check_eq("bp_c9_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp_c9_rdata", rsp_rdata, 32'hC0DE_0004);
    step();
    @(negedge clk_i);
    check_eq("bp_c10_empty", 32'(rsp_valid), 32'd0);
    step();

    // Byte-enable write to addr 7, then read it back.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd7;
    req_wdata = 32'h1122_3344; req_be = 4'b0101;
    @(negedge clk_i);
    check_eq("wr_sram_req", 32'(sram_req), 32'd1);
    check_eq("wr_sram_we", 32'(sram_we), 32'd1);
    check_eq("wr_sram_be", 32'(sram_be), 32'h5);
    check_eq("wr_sram_addr", 32'(sram_addr), 32'd7);
    check_eq("wr_sram_wdata", sram_wdata, 32'h1122_3344);
    step();
    req_we = 1'b0; req_be = 4'b0000; req_wdata = '0;
    @(negedge clk_i);
    check_eq("wr_c1_ready", 32'(req_ready), 32'd1);
    check_eq("wr_c1_sram_we", 32'(sram_we), 32'd0);
    step();
    req_valid = 1'b0;
    @(negedge clk_i);
    check_eq("wr_no_response", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk_i);
    check_eq("wr_rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("wr_rd_rdata", rsp_rdata, 32'h0022_0044);
    step();
    @(negedge clk_i);
    check_eq("wr_rd_done", 32'(rsp_valid), 32'd0);
    step();

    // Streaming: 16 reads back to back with rsp_ready held high.
    rsp_ready = 1'b1;
    n_acc = 0;
    rx = 0;
    for (int k = 0; k < 20; k++) begin
      req_valid = (k < 16);
      req_we    = 1'b0;
      req_addr  = 10'(16 + k);
      @(negedge clk_i);
      if (sram_req) n_acc++;
      if (rsp_valid) begin
        check_eq($sformatf("stream_rdata%0d", rx), rsp_rdata, 32'hC0DE_0000 | 32'(16 + rx));
        rx++;
      end
      step();
    end
    req_valid = 1'b0;
    check_eq("stream_accepts", 32'(n_acc), 32'd16);
    check_eq("stream_responses", 32'(rx), 32'd16);

    // Reset with two responses queued and one read in flight.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req_addr = 10'(k);
      @(negedge clk_i);
      check_eq($sformatf("mr_accept%0d", k), 32'(sram_req), 32'd1);
      step();
    end
    req_valid = 1'b0;
    check_eq("mr_queued_valid", 32'(rsp_valid), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mr_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk_i);
    rst_ni    = 1'b1;
    rsp_ready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check_eq($sformatf("mr_no_stale%0d", k), 32'(rsp_valid), 32'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_stream_adapter.md
SRAM_STREAM_ADAPTER -- requirements
Module: sram_stream_adapter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NumWords, 1024, SRAM depth in words.
- DataWidth, 32, data width in bits.
- ByteWidth, 8, bits per byte enable.
- Latency, 1, downstream SRAM read latency in cycles; must be >= 1.
- NumRspEntries, Latency+2, response credit/FIFO depth; must be >= 1.
- Derived, not to be overridden: AddrWidth = (NumWords>1) ? clog2(NumWords) : 1; BeWidth = ceil(DataWidth/ByteWidth).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_valid_i, in, 1, upstream request valid.
- req_ready_o, out, 1, upstream request ready.
- req_we_i, in, 1, write (1) or read (0).
- req_addr_i, in, AddrWidth, word address.
- req_wdata_i, in, DataWidth, write data.
- req_be_i, in, BeWidth, byte enables.
- rsp_valid_o, out, 1, read response valid.
- rsp_ready_i, in, 1, read response ready.
- rsp_rdata_o, out, DataWidth, read response data.
- sram_req_o, out, 1, SRAM request.
- sram_we_o, out, 1, SRAM write enable.
- sram_addr_o, out, AddrWidth, SRAM address.
- sram_wdata_o, out, DataWidth, SRAM write data.
- sram_be_o, out, BeWidth, SRAM byte enables.
- sram_rdata_i, in, DataWidth, SRAM read data, valid Latency cycles after a read request.

Function
REQ-003 A request handshake is req_valid_i && req_ready_o in one cycle; the response handshake is rsp_valid_o && rsp_ready_i.
REQ-004 sram_req_o SHALL equal req_valid_i && req_ready_o combinationally. sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o SHALL pass through req_we_i, req_addr_i, req_wdata_i and req_be_i unmodified.
REQ-005 An outstanding counter (width clog2(NumRspEntries+1)) SHALL count reads in the SRAM pipeline plus entries held in the response FIFO.
- It increments on an accepted read.
- It decrements on a response handshake.
- When both occur in the same cycle it is unchanged.
REQ-006 req_ready_o SHALL equal (outstanding < NumRspEntries).
- It is registered-state only, with no combinational path from rsp_ready_i or req_valid_i.
- It applies to reads and writes alike.
REQ-007 Writes SHALL produce no response and SHALL NOT change the counter.
REQ-008 A Latency-bit valid shift register SHALL track accepted reads.
- Bit Latency-1 is set on an accepted read.
- The register shifts toward bit 0 every cycle.
- When bit 0 is set, sram_rdata_i is pushed into the FIFO at that clock edge.
REQ-009 The response FIFO SHALL hold NumRspEntries entries, in order, with no bypass.
- A read accepted in cycle 0 has rsp_valid_o at the earliest in cycle Latency+1.
- rsp_valid_o = FIFO non-empty.
- rsp_rdata_o = head entry.
- The head entry is held stable while rsp_valid_o && !rsp_ready_i.
REQ-010 A simultaneous push and pop SHALL be legal at any occupancy, including full and empty. Pointers SHALL wrap modulo NumRspEntries.
REQ-011 FIFO overflow SHALL be impossible by construction (REQ-006). Simulation assertions SHALL flag:
- push while full;
- counter underflow;
- req_addr_i >= NumWords on a handshake.
REQ-012 Sustained throughput SHALL be one read per cycle when rsp_ready_i is held high and NumRspEntries >= Latency+2. Writes SHALL be accepted whenever req_ready_o is high.

Reset
REQ-013 On rst_ni low, asynchronously, the following SHALL reset, and reset values SHALL be data-independent:
- counter = 0;
- shift register = 0;
- FIFO pointers and occupancy = 0;
- rsp_valid_o = 0;
- req_ready_o = 1;
- sram_req_o = req_valid_i.
REQ-014 Reset mid-operation SHALL discard all in-flight reads and queued responses. No response SHALL appear after reset deasserts unless a new read is accepted.

Verification (Latency=1, NumRspEntries=3, DataWidth=32, ByteWidth=8)
REQ-015 Single read: mem[5]=0xA5A5_A5A5, read addr 5 accepted in cycle 0, rsp_ready_i=1 -> rsp_valid_o=1 in cycle 2 only, rdata 0xA5A5_A5A5.
REQ-016 Backpressure: rsp_ready_i=0, reads to addr 1,2,3,4 offered back-to-back.
- Three reads are accepted and req_ready_o=0 from cycle 3.
- On raising rsp_ready_i, data for addr 1,2,3 is returned in order.
- The read to addr 4 is then accepted.
REQ-017 Byte-enable write: write addr 7, data 0x1122_3344, be=4'b0101, then read addr 7 (initial 0) -> response 0x0022_0044.
- sram_be_o equals 4'b0101 during the write.
- No response is produced for the write.
REQ-018 Simultaneous events: counter=2, read accepted and response popped in the same cycle -> counter stays 2 and req_ready_o stays 1. With FIFO full, pop-only -> req_ready_o=1 the next cycle.
REQ-019 Streaming: rsp_ready_i=1, 16 consecutive reads -> 16 accepts in 16 cycles and 16 in-order responses.
REQ-020 Reset mid-operation: rst_ni pulsed low with 2 responses queued and 1 read in flight -> rsp_valid_o=0 immediately, req_ready_o=1, no stale response afterwards.
